phv_action_stage: RTL and testbench

- Parametrised successor to the fixed-width PHV stage action path.
- Applies a per-container action vector to an incoming PHV in a 2-stage elastic pipeline with valid/ready backpressure on both sides.
- Container counts per width group and the metadata length are generics.
- Sits after key-extract/lookup in each RMT stage; the lookup result supplies the action vector alongside the PHV.

---
 rtl/phv_action_stage_if.sv | 26 ++
 rtl/phv_action_stage.sv | 134 +++++++++++++
 tb/tb_phv_action_stage.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phv_action_stage_if.sv
// Stream bundle for the PHV action stage: PHV + action vector in, modified PHV out.
interface phv_action_stage_if #(
   parameter int unsigned PHV_LEN = 1124,
   parameter int unsigned AV_LEN  = 600
);
   logic [PHV_LEN-1:0] phv_in;
   logic [AV_LEN-1:0]  act_vec_in;
   logic               phv_in_valid;
   logic               phv_in_ready;
   logic [PHV_LEN-1:0] phv_out;
   logic               phv_out_valid;
   logic               phv_out_ready;
   logic [31:0]        pkt_cnt;

   // Producer/consumer side (testbench or upstream/downstream glue)
   modport master (
      output phv_in, act_vec_in, phv_in_valid, phv_out_ready,
      input  phv_in_ready, phv_out, phv_out_valid, pkt_cnt
   );

   // The action stage itself
   modport slave (
      input  phv_in, act_vec_in, phv_in_valid, phv_out_ready,
      output phv_in_ready, phv_out, phv_out_valid, pkt_cnt
   );
endinterface

// File: rtl/phv_action_stage.sv
// Per-container action stage: two-stage elastic pipeline applying NOP/ADD/SUB/SETI/COPY to
// every PHV container in parallel. All operands come from the original input PHV.
module phv_action_stage #(
   parameter int unsigned NUM_6B   = 8,
   parameter int unsigned NUM_4B   = 8,
   parameter int unsigned NUM_2B   = 8,
   parameter int unsigned META_LEN = 356,
   parameter int unsigned ACT_LEN  = 25
) (
   input logic               axis_clk,
   input logic               aresetn,
   phv_action_stage_if.slave bus
);
   localparam int unsigned NUM_C   = NUM_6B + NUM_4B + NUM_2B;
   localparam int unsigned PHV_LEN = 48 * NUM_6B + 32 * NUM_4B + 16 * NUM_2B + META_LEN;
   localparam int unsigned OFF_2B  = META_LEN;
   localparam int unsigned OFF_4B  = OFF_2B + 16 * NUM_2B;
   localparam int unsigned OFF_6B  = OFF_4B + 32 * NUM_4B;

   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_SETI = 4'd3;
   localparam logic [3:0] OP_COPY = 4'd4;

   logic               s1_valid, s2_valid;
   logic               s1_adv, s2_adv, s1_load;
   logic [PHV_LEN-1:0] phv_s1;
   logic [PHV_LEN-1:0] phv_out_q;
   logic [31:0]        pkt_cnt_q;
   // Built slice-by-slice from per-container results plus untouched metadata
   wire  [PHV_LEN-1:0] phv_nxt;

   assign s2_adv  = !s2_valid || bus.phv_out_ready;
   assign s1_adv  = !s1_valid || s2_adv;
   assign s1_load = s1_adv && bus.phv_in_valid;

   assign bus.phv_in_ready  = s1_adv;
   assign bus.phv_out       = phv_out_q;
   assign bus.phv_out_valid = s2_valid;
   assign bus.pkt_cnt       = pkt_cnt_q;

   assign phv_nxt[META_LEN-1:0] = phv_s1[META_LEN-1:0];

   for (genvar k = 0; k < NUM_C; k++) begin : g_cont
      // Group 0 = 2B, 1 = 4B, 2 = 6B; action index k follows the same order
      localparam int unsigned G    = (k < NUM_2B) ? 0 : ((k < NUM_2B + NUM_4B) ? 1 : 2);
      localparam int unsigned W    = (G == 0) ? 16 : ((G == 1) ? 32 : 48);
      localparam int unsigned N    = (G == 0) ? NUM_2B : ((G == 1) ? NUM_4B : NUM_6B);
      localparam int unsigned KLO  = (G == 0) ? 0 : ((G == 1) ? NUM_2B : NUM_2B + NUM_4B);
      localparam int unsigned GOFF = (G == 0) ? OFF_2B : ((G == 1) ? OFF_4B : OFF_6B);
      localparam int unsigned OFF  = GOFF + (k - KLO) * W;

      logic [ACT_LEN-1:0] act;
      logic [3:0]         op_d, op_q;
      logic [4:0]         s1_idx, s2_idx;
      logic [15:0]        imm;
      logic [W-1:0]       opa_d, opb_d, opa_q, opb_q, res;

      assign act    = bus.act_vec_in[k*ACT_LEN +: ACT_LEN];
      assign op_d   = act[24:21];
      assign s1_idx = act[20:16];
      assign s2_idx = act[15:11];
      assign imm    = act[15:0];

      // Operand select within the width group; out-of-range indices read zero.
      // SETI reuses operand A to carry the immediate.
      always_comb begin
         opa_d = '0;
         opb_d = '0;
         for (int unsigned j = 0; j < N; j++) begin
            if (32'(s1_idx) == j) opa_d = bus.phv_in[GOFF + j*W +: W];
            if (32'(s2_idx) == j) opb_d = bus.phv_in[GOFF + j*W +: W];
         end
         if (op_d == OP_SETI) opa_d = W'(imm);
      end

      // S1 per-container op and operand registers
      always_ff @(posedge axis_clk or negedge aresetn) begin
         if (!aresetn) begin
            op_q  <= '0;
            opa_q <= '0;
            opb_q <= '0;
         end else if (s1_load) begin
            op_q  <= op_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
         end
      end

      // ALU, modulo 2^W; unknown ops keep the original container
      always_comb begin
         res = phv_s1[OFF +: W];
         case (op_q)
            OP_ADD:           res = opa_q + opb_q;
            OP_SUB:           res = opa_q - opb_q;
            OP_SETI, OP_COPY: res = opa_q;
            default:          ;
         endcase
      end

      assign phv_nxt[OFF +: W] = res;
   end

   // S1 valid and PHV capture
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         s1_valid <= 1'b0;
         phv_s1   <= '0;
      end else if (s1_adv) begin
         s1_valid <= bus.phv_in_valid;
         if (bus.phv_in_valid) phv_s1 <= bus.phv_in;
      end
   end

   // S2 output register; holds while stalled
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         s2_valid  <= 1'b0;
         phv_out_q <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) phv_out_q <= phv_nxt;
      end
   end

   // Output handshake counter, wraps naturally
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         pkt_cnt_q <= '0;
      end else if (s2_valid && bus.phv_out_ready) begin
         pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
   end
endmodule

// File: tb/tb_phv_action_stage.sv
// Randomised and directed bench for phv_action_stage with a container-level reference model.
module tb_phv_action_stage;
   localparam int unsigned N6   = 8;
   localparam int unsigned N4   = 8;
   localparam int unsigned N2   = 8;
   localparam int unsigned META = 356;
   localparam int unsigned ACT  = 25;
   localparam int unsigned NC   = N6 + N4 + N2;
   localparam int unsigned PL   = 48 * N6 + 32 * N4 + 16 * N2 + META;
   localparam int unsigned AL   = NC * ACT;

   typedef logic [PL-1:0] phv_t;
   typedef logic [AL-1:0] av_t;

   logic axis_clk = 1'b0;
   logic aresetn  = 1'b0;
   int   checks   = 0;
   int   errors   = 0;
   int   edge_cnt = 0;

   phv_t        exp_q[$];
   int          acc_q[$];
   int          mdl_cnt = 0;
   logic [47:0] out_tags[$];
   int          out_edges[$];

   phv_action_stage_if #(.PHV_LEN(PL), .AV_LEN(AL)) bus ();

   phv_action_stage #(
      .NUM_6B(N6), .NUM_4B(N4), .NUM_2B(N2), .META_LEN(META), .ACT_LEN(ACT)
   ) dut (
      .axis_clk(axis_clk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   always #5 axis_clk = ~axis_clk;

   initial forever begin
      @(posedge axis_clk);
      edge_cnt++;
   end

   // ---------------- reference model: group 0=2B, 1=4B, 2=6B ----------------
   function automatic int unsigned gw(int g);
      return (g == 0) ? 16 : ((g == 1) ? 32 : 48);
   endfunction
   function automatic int unsigned gn(int g);
      return (g == 0) ? N2 : ((g == 1) ? N4 : N6);
   endfunction
   function automatic int unsigned gk(int g);
      return (g == 0) ? 0 : ((g == 1) ? N2 : N2 + N4);
   endfunction
   function automatic int unsigned goff(int g);
      return (g == 0) ? META : ((g == 1) ? META + 16 * N2 : META + 16 * N2 + 32 * N4);
   endfunction

   function automatic logic [47:0] getc(phv_t p, int g, int i);
      logic [47:0] v;
      v = '0;
      if (i >= int'(gn(g))) return '0;
      for (int b = 0; b < int'(gw(g)); b++) v[b] = p[goff(g) + i * gw(g) + b];
      return v;
   endfunction

   function automatic phv_t putc(phv_t p, int g, int i, logic [47:0] v);
      phv_t r;
      r = p;
      for (int b = 0; b < int'(gw(g)); b++) r[goff(g) + i * gw(g) + b] = v[b];
      return r;
   endfunction

   function automatic phv_t model(phv_t p, av_t a);
      phv_t        r;
      logic [24:0] e;
      logic [47:0] x, y, v, m;
      r = p;
      for (int g = 0; g < 3; g++) begin
         m = (48'd1 << gw(g)) - 48'd1;
         for (int i = 0; i < int'(gn(g)); i++) begin
            e = a[(gk(g) + i) * ACT +: ACT];
            x = getc(p, g, int'(e[20:16]));
            y = getc(p, g, int'(e[15:11]));
            case (e[24:21])
               4'd1:    v = x + y;
               4'd2:    v = x - y;
               4'd3:    v = {32'd0, e[15:0]};
               4'd4:    v = x;
               default: v = getc(p, g, i);
            endcase
            r = putc(r, g, i, v & m);
         end
      end
      return r;
   endfunction

   function automatic logic [24:0] mk(int op, int s1, int s2);
      return {4'(op), 5'(s1), 5'(s2), 11'd0};
   endfunction

   function automatic phv_t rand_phv();
      phv_t p;
      for (int b = 0; b < int'(PL); b++) p[b] = 1'($urandom_range(0, 1));
      return p;
   endfunction

   function automatic av_t rand_av();
      av_t a;
      for (int k = 0; k < int'(NC); k++)
         a[k*ACT +: ACT] = {4'($urandom_range(0, 7)), 5'($urandom_range(0, 9)), 16'($urandom)};
      return a;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_phv(input string nm, input phv_t act, input phv_t exp);
      checks++;
      if (act !== exp) begin
         int          first;
         logic [63:0] wa, we;
         first = 0;
         for (int b = int'(PL) - 1; b >= 0; b--) if (act[b] !== exp[b]) first = b;
         wa = '0;
         we = '0;
         for (int b = 0; b < 64; b++) begin
            if (first + b < int'(PL)) begin
               wa[b] = act[first + b];
               we[b] = exp[first + b];
            end
         end
         errors++;
         $display("FAIL %s: first differing bit %0d, got 0x%016h, expected 0x%016h (from that bit)",
                  nm, first, wa, we);
      end
   endtask

   // ---------------- compare process ----------------
   initial begin : monitor
      phv_t held;
      logic stalled;
      logic exp_valid;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge axis_clk);
         if (!aresetn) begin
            exp_q.delete();
            acc_q.delete();
            mdl_cnt = 0;
            stalled = 1'b0;
         end else begin
            exp_valid = (exp_q.size() > 0) && (edge_cnt >= acc_q[0] + 1);
            chk("out_valid", 64'(bus.phv_out_valid), 64'(exp_valid));
            chk("in_ready", 64'(bus.phv_in_ready),
                64'((exp_q.size() < 2) || bus.phv_out_ready));
            chk("pkt_cnt", 64'(bus.pkt_cnt), 64'(mdl_cnt));
            if (bus.phv_out_valid && exp_valid) chk_phv("phv_out", bus.phv_out, exp_q[0]);
            if (stalled && bus.phv_out_valid) chk_phv("stall_hold", bus.phv_out, held);
            stalled = bus.phv_out_valid && !bus.phv_out_ready;
            held    = bus.phv_out;
            if (bus.phv_out_valid && bus.phv_out_ready && exp_q.size() > 0) begin
               void'(exp_q.pop_front());
               void'(acc_q.pop_front());
               mdl_cnt++;
               out_tags.push_back(getc(bus.phv_out, 0, 0));
               out_edges.push_back(edge_cnt + 1);
            end
            if (bus.phv_in_valid && bus.phv_in_ready) begin
               exp_q.push_back(model(bus.phv_in, bus.act_vec_in));
               acc_q.push_back(edge_cnt + 1);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input phv_t p, input av_t a);
      int budget;
      budget           = 0;
      bus.phv_in       = p;
      bus.act_vec_in   = a;
      bus.phv_in_valid = 1'b1;
      @(negedge axis_clk);
      while (!bus.phv_in_ready && budget < 100) begin
         @(negedge axis_clk);
         budget++;
      end
      if (!bus.phv_in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: phv_in_ready stayed 0, expected 1 within 100 cycles");
      end
      @(posedge axis_clk);
      #1;
      bus.phv_in_valid = 1'b0;
   endtask

   task automatic wait_out(output phv_t o);
      int budget;
      budget = 0;
      o      = '0;
      @(negedge axis_clk);
      while (!(bus.phv_out_valid && bus.phv_out_ready) && budget < 20) begin
         @(negedge axis_clk);
         budget++;
      end
      if (!(bus.phv_out_valid && bus.phv_out_ready)) begin
         checks++;
         errors++;
         $display("FAIL out_timeout: no output transfer, expected one within 20 cycles");
      end else begin
         o = bus.phv_out;
      end
      @(posedge axis_clk);
      #1;
   endtask

   task automatic do_reset();
      bus.phv_in_valid = 1'b0;
      @(posedge axis_clk);
      #3;
      aresetn = 1'b0;
      #1;
      chk("rst_out_valid", 64'(bus.phv_out_valid), 64'd0);
      chk("rst_phv_out_nonzero", 64'(|bus.phv_out), 64'd0);
      chk("rst_pkt_cnt", 64'(bus.pkt_cnt), 64'd0);
      chk("rst_in_ready", 64'(bus.phv_in_ready), 64'd1);
      bus.phv_out_ready = 1'b1;
      repeat (2) @(posedge axis_clk);
      @(negedge axis_clk);
      #2;
      aresetn = 1'b1;
      @(posedge axis_clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin : stim
      phv_t p, m, o, e;
      av_t  a;
      logic saw_nr;
      logic done;
      int   nout;

      bus.phv_in        = '0;
      bus.act_vec_in    = '0;
      bus.phv_in_valid  = 1'b0;
      bus.phv_out_ready = 1'b1;

      // Reset then idle
      do_reset();
      @(negedge axis_clk);
      chk("idle_out_valid", 64'(bus.phv_out_valid), 64'd0);
      chk("idle_pkt_cnt", 64'(bus.pkt_cnt), 64'd0);
      chk("idle_in_ready", 64'(bus.phv_in_ready), 64'd1);
      @(posedge axis_clk);
      #1;

      // Swap C4[7] and C4[6] with two COPYs
      p = rand_phv();
      p = putc(p, 1, 7, 48'hCCCCCCCC);
      p = putc(p, 1, 6, 48'hBBBBBBBB);
      a = '0;
      a[(N2 + 7) * ACT +: ACT] = mk(4, 6, 0);
      a[(N2 + 6) * ACT +: ACT] = mk(4, 7, 0);
      m = model(p, a);
      chk("model_swap_c4_7", 64'(getc(m, 1, 7)), 64'hBBBBBBBB);
      chk("model_swap_c4_6", 64'(getc(m, 1, 6)), 64'hCCCCCCCC);
      send(p, a);
      wait_out(o);
      chk("swap_c4_7", 64'(getc(o, 1, 7)), 64'hBBBBBBBB);
      chk("swap_c4_6", 64'(getc(o, 1, 6)), 64'hCCCCCCCC);
      e = putc(putc(p, 1, 7, 48'hBBBBBBBB), 1, 6, 48'hCCCCCCCC);
      chk_phv("swap_rest", o, e);
      chk("swap_pkt_cnt", 64'(bus.pkt_cnt), 64'd1);

      // Arithmetic wrap, SETI and out-of-range source
      p = rand_phv();
      p = putc(p, 0, 1, 48'hFFFF);
      p = putc(p, 0, 2, 48'h0002);
      p = putc(p, 2, 1, 48'h0);
      p = putc(p, 2, 2, 48'h1);
      a = '0;
      a[0 * ACT +: ACT]             = mk(1, 1, 2);
      a[(N2 + N4 + 0) * ACT +: ACT] = mk(2, 1, 2);
      a[(N2 + 3) * ACT +: ACT]      = {4'd3, 5'd0, 16'hABCD};
      a[5 * ACT +: ACT]             = mk(4, 31, 0);
      m = model(p, a);
      chk("model_add_wrap", 64'(getc(m, 0, 0)), 64'h0001);
      chk("model_sub_wrap", 64'(getc(m, 2, 0)), 64'hFFFFFFFFFFFF);
      chk("model_seti", 64'(getc(m, 1, 3)), 64'h0000ABCD);
      chk("model_bad_src", 64'(getc(m, 0, 5)), 64'h0);
      send(p, a);
      wait_out(o);
      chk("add_wrap", 64'(getc(o, 0, 0)), 64'h0001);
      chk("sub_wrap", 64'(getc(o, 2, 0)), 64'hFFFFFFFFFFFF);
      chk("seti", 64'(getc(o, 1, 3)), 64'h0000ABCD);
      chk("bad_src", 64'(getc(o, 0, 5)), 64'h0);
      chk("meta_pass", 64'(o[63:0]), 64'(p[63:0]));
      chk("arith_pkt_cnt", 64'(bus.pkt_cnt), 64'd2);

      // Backpressure: 5 tagged beats, ready low for cycles 3-6
      do_reset();
      out_tags.delete();
      saw_nr = 1'b0;
      fork
         begin
            for (int t = 1; t <= 5; t++) begin
               p = putc(rand_phv(), 0, 0, 48'(t));
               send(p, '0);
            end
         end
         begin
            for (int c = 0; c < 12; c++) begin
               bus.phv_out_ready = !(c >= 3 && c <= 6);
               @(negedge axis_clk);
               if (!bus.phv_in_ready) saw_nr = 1'b1;
               @(posedge axis_clk);
               #1;
            end
            bus.phv_out_ready = 1'b1;
         end
      join
      repeat (5) @(posedge axis_clk);
      #1;
      chk("bp_in_ready_dropped", 64'(saw_nr), 64'd1);
      chk("bp_out_count", 64'(out_tags.size()), 64'd5);
      for (int i = 0; i < 5 && i < out_tags.size(); i++)
         chk("bp_order", 64'(out_tags[i]), 64'(i + 1));
      chk("bp_pkt_cnt", 64'(bus.pkt_cnt), 64'd5);

      // Reset with two beats in flight
      do_reset();
      bus.phv_out_ready = 1'b0;
      send(rand_phv(), rand_av());
      send(rand_phv(), rand_av());
      @(negedge axis_clk);
      chk("mid_full_valid", 64'(bus.phv_out_valid), 64'd1);
      chk("mid_full_in_ready", 64'(bus.phv_in_ready), 64'd0);
      @(posedge axis_clk);
      #1;
      do_reset();
      nout = 0;
      repeat (6) begin
         @(negedge axis_clk);
         if (bus.phv_out_valid) nout++;
      end
      chk("mid_no_stale", 64'(nout), 64'd0);
      @(posedge axis_clk);
      #1;

      // Streaming: 100 beats, ready held high
      out_edges.delete();
      for (int i = 0; i < 100; i++) send(rand_phv(), rand_av());
      repeat (5) @(posedge axis_clk);
      #1;
      chk("stream_count", 64'(out_edges.size()), 64'd100);
      if (out_edges.size() == 100)
         chk("stream_rate", 64'(out_edges[99] - out_edges[0]), 64'd99);
      chk("stream_pkt_cnt", 64'(bus.pkt_cnt), 64'd100);

      // Random traffic with random backpressure
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge axis_clk);
                  #1;
               end
               send(rand_phv(), rand_av());
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               bus.phv_out_ready = ($urandom_range(0, 3) != 0);
               @(posedge axis_clk);
               #1;
            end
            bus.phv_out_ready = 1'b1;
         end
      join
      repeat (8) @(posedge axis_clk);
      #1;
      chk("rand_pkt_cnt", 64'(bus.pkt_cnt), 64'd400);
      chk("rand_drained", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
